// File: rtl/decode_stage.sv
// decode_stage: ID/EX pipeline register for the 16-bit WISC datapath.
// Splits the instruction into ALU fields, derives destination register and
// memory controls, and tracks HALT retirement through a small state machine.
module decode_stage #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] instr,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              stall,
   input  logic              flush,
   output logic              accept,
   output logic              id_valid,
   output logic [4:0]        OpCode,
   output logic [1:0]        funct,
   output logic [7:0]        Imm,
   output logic [DATA_W-1:0] Pc,
   output logic [REG_AW-1:0] rs_addr,
   output logic [REG_AW-1:0] rt_addr,
   output logic [REG_AW-1:0] rd_addr,
   output logic              reg_write,
   output logic              mem_read,
   output logic              mem_write,
   output logic              halted
);

   typedef enum logic [1:0] {StRun, StHaltPend, StHalted} state_e;

   state_e            state_q;
   logic              id_valid_q;
   logic [4:0]        opcode_q;
   logic [1:0]        funct_q;
   logic [7:0]        imm_q;
   logic [DATA_W-1:0] pc_q;
   logic [REG_AW-1:0] rs_q, rt_q, rd_q;
   logic              reg_write_q, mem_read_q, mem_write_q, halted_q;

   logic [4:0]        dec_op;
   logic [REG_AW-1:0] dec_rd;
   logic              dec_we, dec_mr, dec_mw;

   assign dec_op = instr[15:11];

   // Instruction is consumed only while running and the pipe is free to move.
   assign accept = instr_valid & ~stall & ~flush & (state_q == StRun);

   // Destination register, write enable and memory controls by opcode class.
   always_comb begin
      dec_rd = '0;
      dec_we = 1'b0;
      dec_mr = (dec_op == 5'b10001);
      dec_mw = (dec_op == 5'b10000) | (dec_op == 5'b10011);
      unique casez (dec_op)
         5'b11011, 5'b11010, 5'b11001, 5'b111??: begin
            dec_rd = instr[4:2];
            dec_we = 1'b1;
         end
         5'b010??, 5'b101??, 5'b10001: begin
            dec_rd = instr[7:5];
            dec_we = 1'b1;
         end
         5'b11000, 5'b10010, 5'b10011: begin
            dec_rd = instr[10:8];
            dec_we = 1'b1;
         end
         5'b00110, 5'b00111: begin
            dec_rd = REG_AW'(7);
            dec_we = 1'b1;
         end
         default: begin
            dec_rd = '0;
            dec_we = 1'b0;
         end
      endcase
   end

   // ID/EX register and HALT state machine; priority rst > flush > stall > load.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         id_valid_q  <= 1'b0;
         opcode_q    <= '0;
         funct_q     <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         halted_q    <= 1'b0;
      end else if (flush) begin
         id_valid_q <= 1'b0;
         // A pending HALT was speculative; HALTED itself is terminal.
         if (state_q == StHaltPend) begin
            state_q <= StRun;
         end
      end else if (!stall) begin
         case (state_q)
            StRun: begin
               if (instr_valid) begin
                  id_valid_q  <= 1'b1;
                  opcode_q    <= dec_op;
                  funct_q     <= instr[1:0];
                  imm_q       <= instr[7:0];
                  pc_q        <= pc_in;
                  rs_q        <= instr[10:8];
                  rt_q        <= instr[7:5];
                  rd_q        <= dec_rd;
                  reg_write_q <= dec_we;
                  mem_read_q  <= dec_mr;
                  mem_write_q <= dec_mw;
                  if (dec_op == 5'b00000) begin
                     state_q <= StHaltPend;
                  end
               end else begin
                  id_valid_q <= 1'b0;
               end
            end
            StHaltPend: begin
               id_valid_q <= 1'b0;
               halted_q   <= 1'b1;
               state_q    <= StHalted;
            end
            StHalted: begin
               id_valid_q <= 1'b0;
            end
            default: begin
               id_valid_q <= 1'b0;
               state_q    <= StRun;
            end
         endcase
      end
   end

   assign id_valid  = id_valid_q;
   assign OpCode    = opcode_q;
   assign funct     = funct_q;
   assign Imm       = imm_q;
   assign Pc        = pc_q;
   assign rs_addr   = rs_q;
   assign rt_addr   = rt_q;
   assign rd_addr   = rd_q;
   assign reg_write = reg_write_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage, checked every cycle
// against a behavioural model plus literal expectations at key points.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst, instr_valid, stall, flush;
   logic [15:0] instr, pc_in;
   logic        accept, id_valid, reg_write, mem_read, mem_write, halted;
   logic [4:0]  OpCode;
   logic [1:0]  funct;
   logic [7:0]  Imm;
   logic [15:0] Pc;
   logic [2:0]  rs_addr, rt_addr, rd_addr;

   int n_checks = 0;
   int n_fail   = 0;
   bit checking = 1'b0;

   always #5 clk = ~clk;

   decode_stage #(.DATA_W(16), .REG_AW(3)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .pc_in(pc_in),
      .stall(stall), .flush(flush), .accept(accept), .id_valid(id_valid),
      .OpCode(OpCode), .funct(funct), .Imm(Imm), .Pc(Pc), .rs_addr(rs_addr),
      .rt_addr(rt_addr), .rd_addr(rd_addr), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .halted(halted)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: returns {reg_write, rd} from opcode class rules.
   function automatic logic [3:0] model_dst(input logic [15:0] ins);
      int op;
      op = int'(ins[15:11]);
      if (op == 27 || op == 26 || op == 25 || op >= 28) return {1'b1, ins[4:2]};
      if ((op / 4) == 2 || (op / 4) == 5 || op == 17) return {1'b1, ins[7:5]};
      if (op == 24 || op == 18 || op == 19) return {1'b1, ins[10:8]};
      if (op == 6 || op == 7) return 4'b1111;
      return 4'b0000;
   endfunction

   logic        m_valid, m_pend, m_halted;
   logic [15:0] m_instr, m_pc;

   // Behavioural model of the stage, advanced on each rising edge.
   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0; m_pend <= 1'b0; m_halted <= 1'b0;
         m_instr <= 16'h0; m_pc <= 16'h0;
      end else if (flush) begin
         m_valid <= 1'b0; m_pend <= 1'b0;
      end else if (stall) begin
         m_valid <= m_valid;
      end else if (m_pend) begin
         m_valid <= 1'b0; m_halted <= 1'b1; m_pend <= 1'b0;
      end else if (m_halted) begin
         m_valid <= 1'b0;
      end else if (instr_valid) begin
         m_valid <= 1'b1; m_instr <= instr; m_pc <= pc_in;
         m_pend  <= (instr[15:11] == 5'd0);
      end else begin
         m_valid <= 1'b0;
      end
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (checking) begin
         logic [3:0] d;
         logic       exp_acc;
         exp_acc = instr_valid & ~stall & ~flush & ~m_pend & ~m_halted;
         chk("m_accept", 16'(accept), 16'(exp_acc));
         chk("m_id_valid", 16'(id_valid), 16'(m_valid));
         chk("m_halted", 16'(halted), 16'(m_halted));
         if (m_valid) begin
            d = model_dst(m_instr);
            chk("m_OpCode", 16'(OpCode), 16'(m_instr[15:11]));
            chk("m_funct", 16'(funct), 16'(m_instr[1:0]));
            chk("m_Imm", 16'(Imm), 16'(m_instr[7:0]));
            chk("m_Pc", Pc, m_pc);
            chk("m_rs", 16'(rs_addr), 16'(m_instr[10:8]));
            chk("m_rt", 16'(rt_addr), 16'(m_instr[7:5]));
            chk("m_rd", 16'(rd_addr), 16'(d[2:0]));
            chk("m_reg_write", 16'(reg_write), 16'(d[3]));
            chk("m_mem_read", 16'(mem_read), 16'(m_instr[15:11] == 5'b10001));
            chk("m_mem_write", 16'(mem_write),
                16'(m_instr[15:11] == 5'b10000 || m_instr[15:11] == 5'b10011));
         end
      end
   end

   // One cycle: wait for the edge, then drive this cycle's inputs.
   task automatic cyc(input logic r, input logic v, input logic [15:0] i,
                      input logic [15:0] p, input logic s, input logic f);
      @(posedge clk);
      #1;
      rst = r; instr_valid = v; instr = i; pc_in = p; stall = s; flush = f;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; pc_in = 16'h0;
      stall = 1'b0; flush = 1'b0;
      cyc(1, 0, 16'h0, 16'h0, 0, 0);
      cyc(1, 0, 16'h0, 16'h0, 0, 0);
      checking = 1'b1;
      chk("rst_id_valid", 16'(id_valid), 16'h0);
      chk("rst_halted", 16'(halted), 16'h0);
      chk("rst_OpCode", 16'(OpCode), 16'h0);
      chk("rst_Pc", Pc, 16'h0);
      chk("rst_reg_write", 16'(reg_write), 16'h0);

      // ADD r3,r1,r2
      cyc(0, 1, 16'hD94C, 16'h0010, 0, 0);
      chk("add_accept", 16'(accept), 16'h1);
      cyc(0, 0, 16'h0, 16'h0, 0, 0);
      chk("add_valid", 16'(id_valid), 16'h1);
      chk("add_op", 16'(OpCode), 16'h1B);
      chk("add_rs", 16'(rs_addr), 16'h1);
      chk("add_rt", 16'(rt_addr), 16'h2);
      chk("add_rd", 16'(rd_addr), 16'h3);
      chk("add_we", 16'(reg_write), 16'h1);
      chk("add_pc", Pc, 16'h0010);

      // LBI then ADDI back to back
      cyc(0, 1, 16'hC285, 16'h0012, 0, 0);
      cyc(0, 1, 16'h41BF, 16'h0014, 0, 0);
      chk("lbi_rd", 16'(rd_addr), 16'h2);
      chk("lbi_imm", 16'(Imm), 16'h85);
      cyc(0, 0, 16'h0, 16'h0, 0, 0);
      chk("addi_valid", 16'(id_valid), 16'h1);
      chk("addi_rd", 16'(rd_addr), 16'h5);
      chk("addi_imm", 16'(Imm), 16'hBF);

      // Stall holds ADD while JAL waits
      cyc(0, 1, 16'hD94C, 16'h0020, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 16'h3004, 16'h0030, 1, 0);
         chk("stall_accept", 16'(accept), 16'h0);
         chk("stall_op", 16'(OpCode), 16'h1B);
         chk("stall_pc", Pc, 16'h0020);
      end
      cyc(0, 1, 16'h3004, 16'h0030, 0, 0);
      chk("jal_accept", 16'(accept), 16'h1);
      cyc(0, 0, 16'h0, 16'h0, 0, 0);
      chk("jal_op", 16'(OpCode), 16'h06);
      chk("jal_rd", 16'(rd_addr), 16'h7);
      chk("jal_we", 16'(reg_write), 16'h1);

      // LD, ST, STU memory controls
      cyc(0, 1, 16'h8A45, 16'h0032, 0, 0);
      cyc(0, 1, 16'h8200, 16'h0034, 0, 0);
      chk("ld_mr", 16'(mem_read), 16'h1);
      chk("ld_rd", 16'(rd_addr), 16'h2);
      cyc(0, 1, 16'h9A00, 16'h0036, 0, 0);
      chk("st_mw", 16'(mem_write), 16'h1);
      chk("st_we", 16'(reg_write), 16'h0);
      cyc(0, 0, 16'h0, 16'h0, 0, 0);
      chk("stu_mw", 16'(mem_write), 16'h1);
      chk("stu_rd", 16'(rd_addr), 16'h2);

      // HALT retires and locks the stage until reset
      cyc(0, 1, 16'h0000, 16'h0040, 0, 0);
      chk("halt_accept", 16'(accept), 16'h1);
      cyc(0, 1, 16'hD94C, 16'h0042, 0, 0);
      chk("halt_pend_accept", 16'(accept), 16'h0);
      chk("halt_pend_valid", 16'(id_valid), 16'h1);
      cyc(0, 1, 16'hD94C, 16'h0042, 0, 0);
      chk("halted_set", 16'(halted), 16'h1);
      chk("halted_valid", 16'(id_valid), 16'h0);
      cyc(0, 1, 16'hD94C, 16'h0042, 0, 0);
      chk("halted_accept", 16'(accept), 16'h0);
      cyc(1, 0, 16'h0, 16'h0, 0, 0);
      cyc(0, 0, 16'h0, 16'h0, 0, 0);
      chk("halt_rst", 16'(halted), 16'h0);

      // Flush cancels pending HALT
      cyc(0, 1, 16'h0000, 16'h0050, 0, 0);
      cyc(0, 0, 16'h0, 16'h0, 0, 1);
      cyc(0, 1, 16'hD94C, 16'h0054, 0, 0);
      chk("flush_halt_accept", 16'(accept), 16'h1);
      chk("flush_halt_halted", 16'(halted), 16'h0);
      cyc(0, 0, 16'h0, 16'h0, 0, 0);
      chk("flush_after_op", 16'(OpCode), 16'h1B);
      cyc(0, 0, 16'h0, 16'h0, 0, 0);
      chk("flush_never_halted", 16'(halted), 16'h0);

      // Stall and flush together: flush wins
      cyc(0, 1, 16'hD94C, 16'h0060, 0, 0);
      cyc(0, 1, 16'hD94C, 16'h0062, 1, 1);
      chk("sf_accept", 16'(accept), 16'h0);
      chk("sf_live", 16'(id_valid), 16'h1);
      cyc(0, 0, 16'h0, 16'h0, 0, 0);
      chk("sf_killed", 16'(id_valid), 16'h0);

      cyc(0, 0, 16'h0, 16'h0, 0, 0);
      @(posedge clk);
      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
